truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE, default 1: number of cycles each input vector is held before the response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to begin a 16-vector sweep.
REQ-005 maxterms  input  16  expected maxterm mask; bit k=1 means the function is 0 at vector k.
REQ-006 x, y, w, z  output  1 each  drive signals to the function under test; {x,y,w,z}=idx, x is the MSB.
REQ-007 idx  output  4  current vector index.
REQ-008 s_in  input  1  response of the function under test.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 pass  output  1  high when the captured table equals the expected table; valid from done onward.
REQ-012 table_q  output  16  captured responses; bit k holds s_in at vector k.
REQ-013 mismatch  output  16  per-vector error mask.
REQ-014 first_err  output  4  lowest index with mismatch=1.
REQ-015 err_valid  output  1  high when mismatch is nonzero.

Function
REQ-016 FSM states: IDLE, SETTLE, SAMPLE, FINISH.
REQ-017 IDLE with start=1: latch maxterms, clear table_q, set idx=0 and settle counter=0, go to SETTLE, set busy=1.
REQ-018 SETTLE: hold x,y,w,z=idx and increment the counter; move to SAMPLE when counter reaches SETTLE-1.
REQ-019 SAMPLE: table_q[idx]<=s_in. If idx==15, go to FINISH; otherwise increment idx, clear the counter, and return to SETTLE.
REQ-020 FINISH: compute results, pulse done for exactly one cycle, set busy=0, return to IDLE.
REQ-021 Results computed in FINISH:
  - mismatch = table_q XOR ~maxterms_latched, using the final table including bit 15.
  - pass = (mismatch==0).
  - err_valid = |mismatch.
  - first_err = index of the lowest set bit of mismatch, or 0 when none is set.
REQ-022 Latency: with start sampled at edge 0, done is high in cycle 16*(SETTLE+1)+1.
REQ-023 start while busy=1 is ignored and does not affect the sweep in progress.
REQ-024 start in the same cycle as done cannot occur (done is asserted in FINISH); start in the cycle after done begins a new sweep.
REQ-025 Results (pass, table_q, mismatch, first_err, err_valid) hold until the next accepted start, which clears them.
REQ-026 A change on maxterms during a sweep has no effect; only the latched copy is used.
REQ-027 idx does not wrap: 15 is the terminal index, and the sweep stops after it.
REQ-028 x, y, w, z, and idx are 0 in IDLE.

Reset
REQ-029 rst_n=0 at any edge, including mid-sweep, forces the following, with no done pulse:
  - state IDLE;
  - idx, counter, and x, y, w, z = 0;
  - busy, done, pass, and err_valid = 0;
  - table_q, mismatch, maxterms_latched, and first_err = 0.
REQ-030 While rst_n=0, start is ignored.

Structure
REQ-031 A shared package holds the FSM state enum, the vector width constant (4), the table width constant (16), and the SETTLE bounds.
REQ-032 One sub-module, prio_enc16, computes first_err from mismatch combinationally.
REQ-033 All outputs except x, y, w, and z are registered; x, y, w, and z are driven directly from the idx register.

Verification
REQ-034 SETTLE=1, maxterms=16'h04C4, s_in driven by a correct model of ΠM(2,6,7,10) -> table_q=16'hFB3B, pass=1, err_valid=0, done in cycle 33.
REQ-035 maxterms=16'h3290 (ΠM(4,7,9,12,13)), model correct except s_in=1 at idx 9 -> mismatch=16'h0200, first_err=9, pass=0.
REQ-036 maxterms=16'h0000, s_in tied 0 -> mismatch=16'hFFFF, first_err=0, err_valid=1.
REQ-037 SETTLE=2, start pulsed at cycle 0 and again at cycle 10 -> second start ignored, single done pulse at cycle 49.
REQ-038 rst_n=0 for one cycle while idx=5 -> next cycle IDLE, all outputs 0, no done; a fresh start then sweeps all 16 vectors normally.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and sizing for the truth-table sweeper.
// Holds the FSM state encoding and the SETTLE bounds.
package truth_table_sweeper_pkg;
    localparam int VEC_W      = 4;
    localparam int TBL_W      = 16;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_e;
endpackage

// File: rtl/truth_table_sweeper_prio_enc16.sv
// Lowest-set-bit encoder over the 16-entry mismatch mask.
// Returns 0 when no bit is set.
module prio_enc16
    import truth_table_sweeper_pkg::*;
(
    input  logic [TBL_W-1:0] vec_i,
    output logic [VEC_W-1:0] idx_o
);
    always_comb begin
        idx_o = '0;
        for (int k = TBL_W - 1; k >= 0; k--) begin
            if (vec_i[k]) begin
                idx_o = k[VEC_W-1:0];
            end
        end
    end
endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 input vectors to a 4-input function, captures the
// response and compares it against an expected maxterm mask.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [TBL_W-1:0] maxterms,
    input  logic             s_in,
    output logic             x,
    output logic             y,
    output logic             w,
    output logic             z,
    output logic [VEC_W-1:0] idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TBL_W-1:0] table_q,
    output logic [TBL_W-1:0] mismatch,
    output logic [VEC_W-1:0] first_err,
    output logic             err_valid
);
    localparam int SETTLE_C = (SETTLE < SETTLE_MIN) ? SETTLE_MIN :
                              (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
    localparam logic [VEC_W-1:0] CNT_LAST = VEC_W'(SETTLE_C - 1);
    localparam logic [VEC_W-1:0] IDX_LAST = VEC_W'(TBL_W - 1);

    state_e           state_q;
    logic [VEC_W-1:0] idx_q;
    logic [VEC_W-1:0] cnt_q;
    logic [TBL_W-1:0] mt_q;
    logic [TBL_W-1:0] tbl_q;
    logic [TBL_W-1:0] mis_q;
    logic [VEC_W-1:0] ferr_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             err_q;

    logic [TBL_W-1:0] tbl_d;
    logic [TBL_W-1:0] mis_d;
    logic [VEC_W-1:0] ferr_d;

    // Results are formed from the table as it will look after this sample,
    // so the final vector is included when the sweep closes.
    always_comb begin
        tbl_d        = tbl_q;
        tbl_d[idx_q] = s_in;
    end

    assign mis_d = tbl_d ^ ~mt_q;

    prio_enc16 u_enc (
        .vec_i (mis_d),
        .idx_o (ferr_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mt_q    <= '0;
            tbl_q   <= '0;
            mis_q   <= '0;
            ferr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mt_q    <= maxterms;
                        tbl_q   <= '0;
                        mis_q   <= '0;
                        ferr_q  <= '0;
                        pass_q  <= 1'b0;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    tbl_q <= tbl_d;
                    if (idx_q == IDX_LAST) begin
                        mis_q   <= mis_d;
                        ferr_q  <= ferr_d;
                        pass_q  <= (mis_d == '0);
                        err_q   <= |mis_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_FINISH;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_FINISH: begin
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign x         = idx_q[3];
    assign y         = idx_q[2];
    assign w         = idx_q[1];
    assign z         = idx_q[0];
    assign idx       = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign table_q   = tbl_q;
    assign mismatch  = mis_q;
    assign first_err = ferr_q;
    assign err_valid = err_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: SETTLE=1 and SETTLE=2 instances share
// stimulus and are each checked every cycle against a timing model.
module tb_truth_table_sweeper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] maxterms = '0;
    logic [15:0] resp_tt = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    int          c0 = 0;

    logic [1:0]  s_in_w, x_w, y_w, w_w, z_w;
    logic [1:0]  busy_w, done_w, pass_w, err_w;
    logic [3:0]  idx_w [2];
    logic [3:0]  ferr_w [2];
    logic [15:0] tbl_w [2];
    logic [15:0] mis_w [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int k = 0; k < 16; k++)
            if (v[k]) return 4'(k);
        return 4'd0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gd
        localparam int S = g + 1;
        localparam int P = S + 1;
        localparam int L = 16 * P;

        assign s_in_w[g] = resp_tt[idx_w[g]];

        truth_table_sweeper #(.SETTLE(S)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .maxterms  (maxterms),
            .s_in      (s_in_w[g]),
            .x         (x_w[g]),
            .y         (y_w[g]),
            .w         (w_w[g]),
            .z         (z_w[g]),
            .idx       (idx_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .pass      (pass_w[g]),
            .table_q   (tbl_w[g]),
            .mismatch  (mis_w[g]),
            .first_err (ferr_w[g]),
            .err_valid (err_w[g])
        );

        bit          m_act = 1'b0;
        bit          m_res = 1'b0;
        int          m_t = 0;
        logic [15:0] m_mt = '0;
        logic [15:0] m_resp = '0;
        int          done_cyc = -1;

        // Model: time since the accepting edge defines the whole sweep.
        always @(posedge clk) begin
            if (!rst_n) begin
                m_act <= 1'b0;
                m_res <= 1'b0;
                m_t   <= 0;
                m_mt  <= '0;
            end else if (!m_act) begin
                if (start) begin
                    m_act  <= 1'b1;
                    m_res  <= 1'b0;
                    m_t    <= 1;
                    m_mt   <= maxterms;
                    m_resp <= resp_tt;
                end
            end else begin
                if (m_t == L + 1) m_act <= 1'b0;
                if (m_t == L) m_res <= 1'b1;
                m_t <= m_t + 1;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                automatic logic        e_busy = m_act && m_t <= L;
                automatic logic        e_done = m_act && m_t == L + 1;
                automatic logic [3:0]  e_idx = '0;
                automatic logic [15:0] e_tbl = '0;
                automatic logic [15:0] e_mis = '0;
                automatic logic [71:0] act, exp;
                if (m_act) e_idx = ((m_t - 1) / P > 15) ? 4'd15
                                   : 4'((m_t - 1) / P);
                for (int k = 0; k < 16; k++)
                    if (m_act && (k + 1) * P < m_t) e_tbl[k] = m_resp[k];
                if (m_res) begin
                    e_tbl = m_resp;
                    e_mis = m_resp ^ ~m_mt;
                end
                exp = {e_busy, e_done, e_idx, e_idx, e_tbl, e_mis,
                       lowest(e_mis), |e_mis, m_res && e_mis == 0, 4'h0};
                act = {busy_w[g], done_w[g], idx_w[g],
                       x_w[g], y_w[g], w_w[g], z_w[g], tbl_w[g],
                       mis_w[g], ferr_w[g], err_w[g], pass_w[g], 4'h0};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL cyc%0d S=%0d outputs: got %h want %h",
                             cyc, S, act, exp);
                end
                if (done_w[g] === 1'b1) done_cyc = cyc;
            end
        end
    end

    // Sweep with maxterms scrambled each cycle and an optional
    // extra start pulse at cycle offset 'extra'.
    task automatic run_sweep(input logic [15:0] mt, input logic [15:0] rs,
                             input int extra);
        bit ok = 1'b0;
        @(negedge clk);
        maxterms = mt;
        resp_tt  = rs;
        start    = 1'b1;
        c0       = cyc;
        for (int i = 1; i < 400; i++) begin
            @(negedge clk);
            if (i > 1 && busy_w == 2'b00 && done_w == 2'b00) begin
                start = 1'b0;
                ok = 1'b1;
                break;
            end
            start    = (i == extra);
            maxterms = 16'($urandom);
        end
        start = 1'b0;
        check("sweep_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [15:0] mt, fl;
        bit          hit;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy_w), 32'd0);
        check("rst_tbl", 32'(tbl_w[0]), 32'd0);
        rst_n = 1'b1;

        run_sweep(16'h04C4, ~16'h04C4, 10);
        check("A_tbl", 32'(tbl_w[0]), 32'hFB3B);
        check("A_pass", 32'(pass_w), 32'd3);
        check("A_err", 32'(err_w), 32'd0);
        check("A_done_cyc_s1", 32'(gd[0].done_cyc - c0), 32'd33);
        check("A_done_cyc_s2", 32'(gd[1].done_cyc - c0), 32'd49);

        run_sweep(16'h3290, ~16'h3290 | 16'h0200, -1);
        check("B_mis", 32'(mis_w[0]), 32'h0200);
        check("B_ferr", 32'(ferr_w[1]), 32'd9);
        check("B_pass", 32'(pass_w), 32'd0);

        // Restart on the cycle after done for the SETTLE=1 instance.
        @(negedge clk);
        maxterms = 16'h0000;
        resp_tt  = 16'h0000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (done_w[0] === 1'b1) hit = 1'b1;
        end
        check("C_done_seen", 32'(hit), 32'd1);
        check("C_mis", 32'(mis_w[0]), 32'hFFFF);
        check("C_ferr", 32'(ferr_w[0]), 32'd0);
        check("C_err", 32'(err_w[0]), 32'd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("C_restart_busy", 32'(busy_w[0]), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (busy_w == 2'b00 && done_w == 2'b00) hit = 1'b1;
        end
        check("C_idle", 32'(hit), 32'd1);

        for (int n = 0; n < 6; n++) begin
            mt = 16'($urandom);
            fl = '0;
            if ($urandom_range(0, 2) != 0)
                fl = (16'd1 << $urandom_range(0, 15)) |
                     (16'd1 << $urandom_range(0, 15));
            run_sweep(mt, ~mt ^ fl, $urandom_range(2, 25));
            check("R_mis", 32'(mis_w[1]), 32'(fl));
            check("R_ferr", 32'(ferr_w[0]), 32'(lowest(fl)));
        end

        @(negedge clk);
        maxterms = 16'h1234;
        resp_tt  = ~16'h1234;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (idx_w[0] == 4'd5) hit = 1'b1;
            else @(negedge clk);
        end
        check("D_idx5_seen", 32'(hit), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("D_busy", 32'(busy_w), 32'd0);
        check("D_done", 32'(done_w), 32'd0);
        check("D_idx", 32'(idx_w[0]), 32'd0);
        check("D_tbl", 32'(tbl_w[0]), 32'd0);
        run_sweep(16'h8001, ~16'h8001, -1);
        check("D_tbl2", 32'(tbl_w[0]), 32'h7FFE);
        check("D_pass2", 32'(pass_w), 32'd3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
